layer_priority_compositor: RTL

//  Parametrised N-layer video compositor between object drawers and the VGA output stage.

---
 rtl/layer_compositor_pkg.sv | 14 +
 rtl/layer_priority_compositor_if.sv | 32 +++
 rtl/layer_priority_compositor_priority_select.sv | 24 ++
 rtl/layer_priority_compositor.sv | 56 +++++
 4 files changed

// File: rtl/layer_compositor_pkg.sv
// layer_compositor_pkg: shared types and helpers for the layer priority compositor.
package layer_compositor_pkg;
  localparam int MAX_LAYERS = 16;
  typedef logic [3:0] layer_id_t;
  typedef layer_id_t [MAX_LAYERS-1:0] prio_table_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic prio_table_t identity_table();
    prio_table_t t;
    for (int s = 0; s < MAX_LAYERS; s++) t[s] = layer_id_t'(s);
    return t;
  endfunction
endpackage

// File: rtl/layer_priority_compositor_if.sv
// layer_priority_compositor_if: pixel stream, priority-table port and composited output.
interface layer_priority_compositor_if
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int RGB_W = 8
);
  localparam int IDX_W = idx_w(NUM_LAYERS);
  logic pixel_valid;
  logic start_of_frame;
  logic [NUM_LAYERS-1:0] dr_in;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_in;
  logic [NUM_LAYERS-1:0] layer_en;
  logic prio_wr_en;
  logic [IDX_W-1:0] prio_wr_slot;
  logic [IDX_W-1:0] prio_wr_layer;
  logic drawing_request;
  logic [RGB_W-1:0] rgb_out;
  logic [IDX_W-1:0] winner_id;
  logic pixel_valid_out;
  logic [NUM_LAYERS-1:0] overlap_flags;
  modport master (
    output pixel_valid, start_of_frame, dr_in, rgb_in, layer_en,
           prio_wr_en, prio_wr_slot, prio_wr_layer,
    input  drawing_request, rgb_out, winner_id, pixel_valid_out, overlap_flags
  );
  modport slave (
    input  pixel_valid, start_of_frame, dr_in, rgb_in, layer_en,
           prio_wr_en, prio_wr_slot, prio_wr_layer,
    output drawing_request, rgb_out, winner_id, pixel_valid_out, overlap_flags
  );
endinterface

// File: rtl/layer_priority_compositor_priority_select.sv
// priority_select: first table slot whose layer has an effective request wins.
module priority_select
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  localparam int IDX_W = idx_w(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] eff,
  input  logic [NUM_LAYERS-1:0][IDX_W-1:0] tbl,
  output logic win,
  output logic [IDX_W-1:0] winner_id
);
  // Scan from the lowest rank upward so the highest-priority slot overrides.
  always_comb begin
    win = 1'b0;
    winner_id = '0;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if (eff[tbl[s]]) begin
        win = 1'b1;
        winner_id = tbl[s];
      end
    end
  end
endmodule

// File: rtl/layer_priority_compositor.sv
// layer_priority_compositor: programmable-priority layer mux with colour key and overlap flags.
module layer_priority_compositor
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int RGB_W = 8,
  parameter logic [RGB_W-1:0] TRANSP_KEY = RGB_W'(8'hFF),
  parameter bit TRANSP_EN = 1'b1,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input logic clk,
  input logic reset,
  layer_priority_compositor_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_LAYERS);
  localparam prio_table_t ID_TBL = identity_table();
  logic [NUM_LAYERS-1:0][IDX_W-1:0] tbl;
  logic [NUM_LAYERS-1:0] eff;
  logic win, multi;
  logic [IDX_W-1:0] win_id;
  always_comb begin
    eff = '0;
    for (int k = 0; k < NUM_LAYERS; k++)
      eff[k] = bus.dr_in[k] & bus.layer_en[k] &
               !(TRANSP_EN && bus.rgb_in[k*RGB_W +: RGB_W] == TRANSP_KEY);
  end
  assign multi = (eff & (eff - 1'b1)) != '0;
  priority_select #(.NUM_LAYERS(NUM_LAYERS)) u_sel (
    .eff(eff),
    .tbl(tbl),
    .win(win),
    .winner_id(win_id)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_LAYERS; s++) tbl[s] <= ID_TBL[s][IDX_W-1:0];
      bus.drawing_request <= 1'b0;
      bus.rgb_out <= BG_COLOR;
      bus.winner_id <= '0;
      bus.pixel_valid_out <= 1'b0;
      bus.overlap_flags <= '0;
    end else begin
      bus.pixel_valid_out <= bus.pixel_valid;
      if (bus.prio_wr_en && int'(bus.prio_wr_slot) < NUM_LAYERS && int'(bus.prio_wr_layer) < NUM_LAYERS)
        tbl[bus.prio_wr_slot] <= bus.prio_wr_layer;
      if (bus.pixel_valid) begin
        bus.drawing_request <= win;
        bus.rgb_out <= win ? bus.rgb_in[int'(win_id)*RGB_W +: RGB_W] : BG_COLOR;
        bus.winner_id <= win ? win_id : '0;
      end
      // Frame clear takes effect before this pixel's overlap bits are merged in.
      bus.overlap_flags <= (bus.start_of_frame ? '0 : bus.overlap_flags) |
                           ((bus.pixel_valid && multi) ? eff : '0);
    end
  end
endmodule
